// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter and its transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned CLK_FREQ     = 50_000_000;
  localparam int unsigned UART_BPS     = 115_200;
  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / UART_BPS;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-launch handshake between the arbiter (master) and uart_tx (slave).
interface uart_tx_if;
  logic [7:0] uart_tx_data;
  logic       uart_tx_en;
  logic       uart_tx_busy;

  modport master (output uart_tx_data, output uart_tx_en, input uart_tx_busy);
  modport slave  (input uart_tx_data, input uart_tx_en, output uart_tx_busy);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART byte transmitter: start bit, 8 data bits LSB first, stop bit.
module uart_tx #(
  parameter int unsigned CLK_FREQ = uart_pkg::CLK_FREQ,
  parameter int unsigned UART_BPS = uart_pkg::UART_BPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_tx_en,
  input  logic [7:0] uart_tx_data,
  output logic       uart_tx_busy,
  output logic       uart_txd
);

  localparam int unsigned CPB      = CLK_FREQ / UART_BPS;
  localparam logic [15:0] CPB_LAST = 16'(CPB - 1);

  logic       busy_q;
  logic       txd_q;
  logic [8:0] shift_q;
  logic [15:0] baud_q;
  logic [3:0] bit_q;

  // Frame sequencer: start bit goes out directly, then the shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      txd_q   <= 1'b1;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
    end else if (!busy_q) begin
      if (uart_tx_en) begin
        busy_q  <= 1'b1;
        txd_q   <= 1'b0;
        shift_q <= {1'b1, uart_tx_data};
        baud_q  <= '0;
        bit_q   <= '0;
      end
    end else if (baud_q == CPB_LAST) begin
      baud_q <= '0;
      if (bit_q == 4'd9) begin
        busy_q <= 1'b0;
        txd_q  <= 1'b1;
      end else begin
        bit_q   <= bit_q + 4'd1;
        txd_q   <= shift_q[0];
        shift_q <= {1'b1, shift_q[8:1]};
      end
    end else begin
      baud_q <= baud_q + 16'd1;
    end
  end

  assign uart_tx_busy = busy_q;
  assign uart_txd     = txd_q;

endmodule

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]     gnt_idx,
  output logic               any
);

  // Scan last+1 .. last+NUM_REQ modulo NUM_REQ, keep the first hit
  always_comb begin
    int unsigned idx;
    logic [IDW-1:0] idx_w;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(last) + k) % NUM_REQ;
      idx_w = IDW'(idx);
      if (!any && req[idx_w]) begin
        any               = 1'b1;
        gnt_idx           = idx_w;
        gnt_onehot[idx_w] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned BUSY_TIMEOUT = 8,
  localparam int unsigned IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   req_done,
  output logic                 tx_err,
  output logic                 arb_busy,
  output logic [IDW-1:0]       owner,
  uart_tx_if.master            tx
);

  localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [IDW-1:0]     last_q, last_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic               en_q, en_d;
  logic [7:0]         data_q, data_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic               abusy_q, abusy_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic               grant;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last       (last_q),
    .gnt_onehot (pick_oh),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  // A foreign launch (busy while idle) blocks granting until it ends
  assign grant = (state_q == IDLE) && pick_any && !tx.uart_tx_busy;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(NUM_REQ - 1);
      cnt_q   <= '0;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= '0;
      owner_q <= '0;
      abusy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      abusy_q <= abusy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant) state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx.uart_tx_busy)        state_d = WAIT_DONE;
        else if (cnt_q == TMO_LAST) state_d = IDLE;
      end
      WAIT_DONE: if (!tx.uart_tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and last grant
  always_comb begin
    ack_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    en_d    = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    abusy_d = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          data_d  = req_data[8*pick_idx +: 8];
          en_d    = 1'b1;
          ack_d   = pick_oh;
          owner_d = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      WAIT_BUSY: begin
        if (!tx.uart_tx_busy) begin
          if (cnt_q == TMO_LAST) err_d = 1'b1;
          else                   cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx.uart_tx_busy) done_d[owner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ack         = ack_q;
  assign req_done        = done_q;
  assign tx_err          = err_q;
  assign arb_busy        = abusy_q;
  assign owner           = owner_q;
  assign tx.uart_tx_en   = en_q;
  assign tx.uart_tx_data = data_q;

endmodule
